// File: rtl/trdb_pkg.sv
// Shared types and defaults for the trace packet scheduler.
//   trdb_format_e / trdb_subformat_e : packet format and subformat codes
//   trdb_sched_state_e               : scheduler sequencing states
//   BMAP_LEN_DEFAULT / RESYNC_MAX_DEFAULT : default capacities
//   pkt_branch_field                 : branch-count field encoding for a packet
package trdb_pkg;

    localparam int unsigned BMAP_LEN_DEFAULT   = 31;
    localparam logic [15:0] RESYNC_MAX_DEFAULT = 16'd1024;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_subformat_e;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SUPPORT = 3'd1,
        ST_START   = 3'd2,
        ST_TRACING = 3'd3,
        ST_STOP    = 3'd4
    } trdb_sched_state_e;

    // A full map in an F1 packet is signalled by a zero count.
    function automatic logic [4:0] pkt_branch_field(input trdb_format_e fmt,
                                                    input logic [4:0]   cnt,
                                                    input logic         full);
        logic [4:0] field;
        if ((fmt == F_DIFF_DELTA) && full) begin
            field = 5'd0;
        end else begin
            field = cnt;
        end
        return field;
    endfunction

endpackage

// File: rtl/trdb_branch_map.sv
// Branch map: records the taken/not-taken outcome of conditional branches.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : empty the map (applied before any shift in the same cycle)
//   shift_i       : record one branch; taken_i gives its outcome
//   count_nx_o    : entry count after this cycle's clear/shift
//   map_nx_o      : map contents after this cycle's clear/shift (1 = not taken)
//   full_nx_o     : map holds BMAP_LEN entries after this cycle
module trdb_branch_map
    import trdb_pkg::*;
#(
    parameter int unsigned BMAP_LEN = BMAP_LEN_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                shift_i,
    input  logic                taken_i,
    output logic [4:0]          count_nx_o,
    output logic [BMAP_LEN-1:0] map_nx_o,
    output logic                full_nx_o
);

    localparam logic [4:0] BMAP_LEN_C = 5'(BMAP_LEN);

    logic [4:0]          count_q, count_d;
    logic [BMAP_LEN-1:0] map_q,   map_d;

    // Next map: clear first so a branch in the clearing cycle lands at bit 0.
    always_comb begin
        count_d = count_q;
        map_d   = map_q;
        if (clear_i) begin
            count_d = 5'd0;
            map_d   = {BMAP_LEN{1'b0}};
        end else begin
            count_d = count_q;
            map_d   = map_q;
        end
        if (shift_i && (count_d < BMAP_LEN_C)) begin
            map_d[count_d] = ~taken_i;
            count_d        = count_d + 5'd1;
        end else begin
            count_d = count_d;
        end
    end

    // Map state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 5'd0;
            map_q   <= {BMAP_LEN{1'b0}};
        end else begin
            count_q <= count_d;
            map_q   <= map_d;
        end
    end

    assign count_nx_o = count_d;
    assign map_nx_o   = map_d;
    assign full_nx_o  = (count_d == BMAP_LEN_C);

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Trace packet scheduler: decides per retired instruction whether a packet is
// due, and with which format/subformat, then offers it to the emitter.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   trace_enable_i       : encoder enable level
//   inst_valid_i, iaddr_i, is_branch_i, branch_taken_i, exception_i,
//   updiscon_i, privchange_i : retirement event (held while stall_o=1)
//   pkt_ready_i          : emitter accepts the request
//   pkt_valid_o, pkt_format_o, pkt_subformat_o, pkt_iaddr_o,
//   branches_o, branch_map_o : registered packet request
//   stall_o              : request pending and not accepted this cycle
module trdb_packet_scheduler
    import trdb_pkg::*;
#(
    parameter logic [15:0] RESYNC_MAX = RESYNC_MAX_DEFAULT,
    parameter int unsigned BMAP_LEN   = BMAP_LEN_DEFAULT,
    parameter int unsigned XLEN       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                trace_enable_i,
    input  logic                inst_valid_i,
    input  logic [XLEN-1:0]     iaddr_i,
    input  logic                is_branch_i,
    input  logic                branch_taken_i,
    input  logic                exception_i,
    input  logic                updiscon_i,
    input  logic                privchange_i,
    input  logic                pkt_ready_i,
    output logic                pkt_valid_o,
    output trdb_format_e        pkt_format_o,
    output trdb_subformat_e     pkt_subformat_o,
    output logic [XLEN-1:0]     pkt_iaddr_o,
    output logic [4:0]          branches_o,
    output logic [BMAP_LEN-1:0] branch_map_o,
    output logic                stall_o
);

    localparam logic [15:0] RESYNC_LAST = RESYNC_MAX - 16'd1;

    trdb_sched_state_e   state_q, state_d;
    logic                pkt_valid_q, pkt_valid_d;
    trdb_format_e        pkt_format_q, pkt_format_d;
    trdb_subformat_e     pkt_subformat_q, pkt_subformat_d;
    logic [XLEN-1:0]     pkt_iaddr_q, pkt_iaddr_d;
    logic [4:0]          branches_q, branches_d;
    logic [BMAP_LEN-1:0] bmap_q, bmap_d;
    logic [15:0]         resync_q, resync_d;
    logic [XLEN-1:0]     last_iaddr_q, last_iaddr_d;
    logic                seen_q, seen_d;

    logic                accept_s, free_s, retire_s, record_s, sync_accept_s;
    logic [15:0]         resync_base_s;
    logic                resync_due_s;
    logic                issue_s;
    trdb_format_e        fmt_s;
    trdb_subformat_e     sub_s;
    logic [XLEN-1:0]     addr_s;
    logic [4:0]          cnt_nx_s;
    logic [BMAP_LEN-1:0] map_nx_s;
    logic                full_nx_s;

    assign accept_s = pkt_valid_q & pkt_ready_i;
    // The request slot is usable when empty or being emptied this cycle.
    assign free_s   = ~pkt_valid_q | pkt_ready_i;
    assign stall_o  = pkt_valid_q & ~pkt_ready_i;
    assign retire_s = inst_valid_i & free_s & trace_enable_i &
                      ((state_q == ST_START) | (state_q == ST_TRACING));
    assign record_s = retire_s & is_branch_i & (state_q == ST_TRACING);
    assign sync_accept_s = accept_s & (pkt_format_q == F_SYNC) &
                           ((pkt_subformat_q == SF_START) | (pkt_subformat_q == SF_TRAP));

    trdb_branch_map #(.BMAP_LEN(BMAP_LEN)) u_bmap (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (accept_s),
        .shift_i    (record_s),
        .taken_i    (branch_taken_i),
        .count_nx_o (cnt_nx_s),
        .map_nx_o   (map_nx_s),
        .full_nx_o  (full_nx_s)
    );

    // Resync counter: a retirement in the clearing cycle counts from zero.
    always_comb begin
        resync_base_s = resync_q;
        if (sync_accept_s) begin
            resync_base_s = 16'd0;
        end else begin
            resync_base_s = resync_q;
        end
        resync_due_s = (resync_base_s == RESYNC_LAST);
        if (retire_s && !resync_due_s) begin
            resync_d = resync_base_s + 16'd1;
        end else begin
            resync_d = resync_base_s;
        end
    end

    // Sequencing FSM and packet selection; acts only when the slot is free.
    always_comb begin
        state_d      = state_q;
        issue_s      = 1'b0;
        fmt_s        = F_OPT_EXT;
        sub_s        = SF_START;
        addr_s       = {XLEN{1'b0}};
        last_iaddr_d = last_iaddr_q;
        seen_d       = seen_q;
        if (free_s) begin
            case (state_q)
                ST_OFF: begin
                    if (trace_enable_i) begin
                        state_d = ST_SUPPORT;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                ST_SUPPORT: begin
                    issue_s = 1'b1;
                    fmt_s   = F_SYNC;
                    sub_s   = SF_SUPPORT;
                    state_d = ST_START;
                end
                ST_START: begin
                    if (!trace_enable_i) begin
                        state_d = ST_OFF;
                    end else if (retire_s) begin
                        issue_s      = 1'b1;
                        fmt_s        = F_SYNC;
                        sub_s        = SF_START;
                        addr_s       = iaddr_i;
                        last_iaddr_d = iaddr_i;
                        seen_d       = 1'b0;
                        state_d      = ST_TRACING;
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_TRACING: begin
                    if (!trace_enable_i) begin
                        state_d = ST_STOP;
                    end else if (retire_s) begin
                        last_iaddr_d = iaddr_i;
                        seen_d       = 1'b1;
                        addr_s       = iaddr_i;
                        if (exception_i) begin
                            issue_s = 1'b1;
                            fmt_s   = F_SYNC;
                            sub_s   = SF_TRAP;
                        end else if (privchange_i || resync_due_s) begin
                            issue_s = 1'b1;
                            fmt_s   = F_SYNC;
                            sub_s   = SF_START;
                        end else if (updiscon_i) begin
                            issue_s = 1'b1;
                            if (cnt_nx_s != 5'd0) begin
                                fmt_s = F_DIFF_DELTA;
                            end else begin
                                fmt_s = F_ADDR_ONLY;
                            end
                        end else if (full_nx_s) begin
                            issue_s = 1'b1;
                            fmt_s   = F_DIFF_DELTA;
                        end else begin
                            issue_s = 1'b0;
                        end
                    end else begin
                        state_d = ST_TRACING;
                    end
                end
                ST_STOP: begin
                    // Nothing retired since the sync packet: nothing to flush.
                    if (seen_q) begin
                        issue_s = 1'b1;
                        addr_s  = last_iaddr_q;
                        if (cnt_nx_s != 5'd0) begin
                            fmt_s = F_DIFF_DELTA;
                        end else begin
                            fmt_s = F_ADDR_ONLY;
                        end
                    end else begin
                        issue_s = 1'b0;
                    end
                    seen_d  = 1'b0;
                    state_d = ST_OFF;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Request register: load on issue, otherwise hold until accepted.
    always_comb begin
        pkt_valid_d     = pkt_valid_q & ~pkt_ready_i;
        pkt_format_d    = pkt_format_q;
        pkt_subformat_d = pkt_subformat_q;
        pkt_iaddr_d     = pkt_iaddr_q;
        branches_d      = branches_q;
        bmap_d          = bmap_q;
        if (issue_s) begin
            pkt_valid_d     = 1'b1;
            pkt_format_d    = fmt_s;
            pkt_subformat_d = sub_s;
            pkt_iaddr_d     = addr_s;
            branches_d      = pkt_branch_field(fmt_s, cnt_nx_s, full_nx_s);
            bmap_d          = map_nx_s;
        end else begin
            pkt_valid_d = pkt_valid_q & ~pkt_ready_i;
        end
    end

    // State and request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_OFF;
            pkt_valid_q     <= 1'b0;
            pkt_format_q    <= F_OPT_EXT;
            pkt_subformat_q <= SF_START;
            pkt_iaddr_q     <= {XLEN{1'b0}};
            branches_q      <= 5'd0;
            bmap_q          <= {BMAP_LEN{1'b0}};
            resync_q        <= 16'd0;
            last_iaddr_q    <= {XLEN{1'b0}};
            seen_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pkt_valid_q     <= pkt_valid_d;
            pkt_format_q    <= pkt_format_d;
            pkt_subformat_q <= pkt_subformat_d;
            pkt_iaddr_q     <= pkt_iaddr_d;
            branches_q      <= branches_d;
            bmap_q          <= bmap_d;
            resync_q        <= resync_d;
            last_iaddr_q    <= last_iaddr_d;
            seen_q          <= seen_d;
        end
    end

    assign pkt_valid_o     = pkt_valid_q;
    assign pkt_format_o    = pkt_format_q;
    assign pkt_subformat_o = pkt_subformat_q;
    assign pkt_iaddr_o     = pkt_iaddr_q;
    assign branches_o      = branches_q;
    assign branch_map_o    = bmap_q;

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Self-checking bench for trdb_packet_scheduler: vector table for the main
// per-instruction decisions, hand sequences for stall, stop and reset cases,
// and an acceptance-time scoreboard for every packet.
module tb_trdb_packet_scheduler;
    import trdb_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BML  = 31;
    localparam logic [15:0] RMAX = 16'd40;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            trace_enable_i = 1'b0;
    logic            inst_valid_i = 1'b0;
    logic [XLEN-1:0] iaddr_i = 32'h0;
    logic            is_branch_i = 1'b0;
    logic            branch_taken_i = 1'b0;
    logic            exception_i = 1'b0;
    logic            updiscon_i = 1'b0;
    logic            privchange_i = 1'b0;
    logic            pkt_ready_i = 1'b1;
    logic            pkt_valid_o;
    trdb_format_e    pkt_format_o;
    trdb_subformat_e pkt_subformat_o;
    logic [XLEN-1:0] pkt_iaddr_o;
    logic [4:0]      branches_o;
    logic [BML-1:0]  branch_map_o;
    logic            stall_o;

    trdb_packet_scheduler #(.RESYNC_MAX(RMAX), .BMAP_LEN(BML), .XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .trace_enable_i(trace_enable_i),
        .inst_valid_i(inst_valid_i), .iaddr_i(iaddr_i), .is_branch_i(is_branch_i),
        .branch_taken_i(branch_taken_i), .exception_i(exception_i),
        .updiscon_i(updiscon_i), .privchange_i(privchange_i),
        .pkt_ready_i(pkt_ready_i), .pkt_valid_o(pkt_valid_o),
        .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o),
        .pkt_iaddr_o(pkt_iaddr_o), .branches_o(branches_o),
        .branch_map_o(branch_map_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  fmt;
        logic [1:0]  sub;
        logic [31:0] iaddr;
        logic [4:0]  br;
        logic [30:0] map;
    } pkt_t;

    typedef struct {
        logic [31:0] iaddr;
        logic        br, tk, exc, upd, prv;
        logic        has_pkt;
        pkt_t        exp;
    } vec_t;

    pkt_t exp_q[$];
    vec_t vecs[11];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic pkt_t mkp(input logic [1:0] f, input logic [1:0] s,
                                 input logic [31:0] a, input logic [4:0] b,
                                 input logic [30:0] m);
        pkt_t p;
        p.fmt = f; p.sub = s; p.iaddr = a; p.br = b; p.map = m;
        return p;
    endfunction

    function automatic vec_t mkv(input logic [31:0] a, input logic b, input logic tk,
                                 input logic exc, input logic upd, input logic prv,
                                 input logic has, input pkt_t e);
        vec_t v;
        v.iaddr = a; v.br = b; v.tk = tk; v.exc = exc; v.upd = upd; v.prv = prv;
        v.has_pkt = has; v.exp = e;
        return v;
    endfunction

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard: compare each packet at the negedge before its accepting edge.
    always @(negedge clk_i) begin
        if (rst_ni && pkt_valid_o && pkt_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pkt: got fmt %0d sub %0d iaddr 0x%0h, expected none",
                         pkt_format_o, pkt_subformat_o, pkt_iaddr_o);
            end else begin
                pkt_t e;
                e = exp_q.pop_front();
                check("pkt_format",    64'(pkt_format_o),    64'(e.fmt));
                check("pkt_subformat", 64'(pkt_subformat_o), 64'(e.sub));
                check("pkt_iaddr",     64'(pkt_iaddr_o),     64'(e.iaddr));
                check("branches",      64'(branches_o),      64'(e.br));
                check("branch_map",    64'(branch_map_o),    64'(e.map));
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        trace_enable_i = 1'b0; inst_valid_i = 1'b0; iaddr_i = 32'h0;
        is_branch_i = 1'b0; branch_taken_i = 1'b0; exception_i = 1'b0;
        updiscon_i = 1'b0; privchange_i = 1'b0; pkt_ready_i = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic retire(input logic [31:0] a, input logic b, input logic tk,
                          input logic exc, input logic upd, input logic prv);
        bit done;
        @(posedge clk_i); #1;
        iaddr_i = a; is_branch_i = b; branch_taken_i = tk;
        exception_i = exc; updiscon_i = upd; privchange_i = prv;
        inst_valid_i = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk_i);
            if (!stall_o) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL retire_timeout: stall_o still 1, expected 0 within 200 cycles");
        end
        @(posedge clk_i); #1;
        inst_valid_i = 1'b0; is_branch_i = 1'b0; branch_taken_i = 1'b0;
        exception_i = 1'b0; updiscon_i = 1'b0; privchange_i = 1'b0;
    endtask

    // Enable tracing and wait for the support packet to be offered.
    task automatic start_trace(input logic [31:0] a);
        bit done;
        exp_q.push_back(mkp(F_SYNC, SF_SUPPORT, 32'h0, 5'd0, 31'h0));
        exp_q.push_back(mkp(F_SYNC, SF_START, a, 5'd0, 31'h0));
        @(posedge clk_i); #1 trace_enable_i = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk_i);
            if (pkt_valid_o) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL support_timeout: pkt_valid_o 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic drain(input string name);
        repeat (6) @(posedge clk_i);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mkp(2'd0, 2'd0, 32'h0, 5'd0, 31'h0));
        vecs[1]  = mkv(32'h1004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mkp(2'd0, 2'd0, 32'h0, 5'd0, 31'h0));
        vecs[2]  = mkv(32'h1008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mkp(2'd0, 2'd0, 32'h0, 5'd0, 31'h0));
        vecs[3]  = mkv(32'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mkp(F_DIFF_DELTA, SF_START, 32'h0100, 5'd3, 31'h2));
        vecs[4]  = mkv(32'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mkp(F_ADDR_ONLY, SF_START, 32'h0200, 5'd0, 31'h0));
        vecs[5]  = mkv(32'h0300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mkp(2'd0, 2'd0, 32'h0, 5'd0, 31'h0));
        vecs[6]  = mkv(32'h0304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mkp(F_SYNC, SF_START, 32'h0304, 5'd1, 31'h1));
        vecs[7]  = mkv(32'h0400, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mkp(F_DIFF_DELTA, SF_START, 32'h0400, 5'd1, 31'h0));
        vecs[8]  = mkv(32'h0500, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, mkp(F_SYNC, SF_TRAP, 32'h0500, 5'd1, 31'h1));
        vecs[9]  = mkv(32'h0600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mkp(2'd0, 2'd0, 32'h0, 5'd0, 31'h0));
        vecs[10] = mkv(32'h0604, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mkp(F_ADDR_ONLY, SF_START, 32'h0604, 5'd0, 31'h0));

        do_reset();
        @(negedge clk_i);
        check("reset_pkt_valid", 64'(pkt_valid_o),     64'd0);
        check("reset_format",    64'(pkt_format_o),    64'd0);
        check("reset_subformat", 64'(pkt_subformat_o), 64'd0);
        check("reset_iaddr",     64'(pkt_iaddr_o),     64'd0);
        check("reset_branches",  64'(branches_o),      64'd0);
        check("reset_map",       64'(branch_map_o),    64'd0);
        check("reset_stall",     64'(stall_o),         64'd0);

        // Start sequence and sync latency, then the decision table.
        start_trace(32'h8000_0000);
        retire(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sync_latency_valid", 64'(pkt_valid_o),     64'd1);
        check("sync_latency_sub",   64'(pkt_subformat_o), 64'(SF_START));
        check("sync_latency_iaddr", 64'(pkt_iaddr_o),     64'h8000_0000);
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].has_pkt) exp_q.push_back(vecs[i].exp);
            retire(vecs[i].iaddr, vecs[i].br, vecs[i].tk, vecs[i].exc, vecs[i].upd, vecs[i].prv);
        end
        drain("table_queue_empty");

        // 31 not-taken branches fill the map on the last one.
        do_reset();
        start_trace(32'h8000_0000);
        retire(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mkp(F_DIFF_DELTA, SF_START, 32'h2078, 5'd0, 31'h7FFF_FFFF));
        for (int i = 0; i < 31; i++) begin
            retire(32'h2000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drain("full_map_queue_empty");

        // Exception on the resync-expiry instruction, then a full resync interval.
        do_reset();
        start_trace(32'h8000_0000);
        retire(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 39; i++) retire(32'h3000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mkp(F_SYNC, SF_TRAP, 32'h5000, 5'd0, 31'h0));
        retire(32'h5000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 39; i++) retire(32'h6000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mkp(F_SYNC, SF_START, 32'h7000, 5'd0, 31'h0));
        retire(32'h7000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("resync_queue_empty");

        // Back-pressure: five stalled cycles with the next retirement held.
        do_reset();
        start_trace(32'h8000_0000);
        retire(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mkp(F_ADDR_ONLY, SF_START, 32'h0500, 5'd0, 31'h0));
        exp_q.push_back(mkp(F_ADDR_ONLY, SF_START, 32'h0600, 5'd0, 31'h0));
        retire(32'h0500, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pkt_ready_i = 1'b0;
        iaddr_i = 32'h0600; updiscon_i = 1'b1; inst_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("stall_high",   64'(stall_o),      64'd1);
            check("stall_iaddr",  64'(pkt_iaddr_o),  64'h0500);
            check("stall_format", 64'(pkt_format_o), 64'(F_ADDR_ONLY));
            @(posedge clk_i); #1;
        end
        pkt_ready_i = 1'b1;
        @(negedge clk_i);
        check("stall_release", 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        inst_valid_i = 1'b0; updiscon_i = 1'b0;
        drain("stall_queue_empty");

        // Disable with two branches pending, then disable right after sync.
        do_reset();
        start_trace(32'h8000_0000);
        retire(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        retire(32'h0700, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        retire(32'h0704, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mkp(F_DIFF_DELTA, SF_START, 32'h0704, 5'd2, 31'h2));
        @(posedge clk_i); #1 trace_enable_i = 1'b0;
        drain("stop_queue_empty");
        @(negedge clk_i);
        check("off_pkt_valid", 64'(pkt_valid_o), 64'd0);
        start_trace(32'h9000_0000);
        retire(32'h9000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i); #1 trace_enable_i = 1'b0;
        drain("stop_empty_queue_empty");

        // Reset while a request is stalled drops it at once.
        do_reset();
        pkt_ready_i = 1'b0;
        start_trace(32'h8000_0000);
        #1 rst_ni = 1'b0;
        #1;
        check("rst_mid_pkt_valid", 64'(pkt_valid_o), 64'd0);
        check("rst_mid_stall",     64'(stall_o),     64'd0);
        exp_q.delete();
        trace_enable_i = 1'b0;
        pkt_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        drain("final_queue_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
